bit_sync_filt: RTL and testbench
================================

Name: bit_sync_filt

Overview:
- Parameterised multi-bit level synchroniser for asynchronous control inputs such as UART RX lines, external enables and status strobes.
- Each channel gets an N-flop metastability chain, then a per-channel glitch filter (stable-count qualifier), then registered rise/fall edge-pulse detection.
- Sits at the boundary between asynchronous pins or foreign clock domains and the BitSync_CLK domain.
- Each channel is independent; no bus coherency is guaranteed across channels.

Parameters:
- STAGES, 2, synchroniser flop depth per channel; legal >= 2.
- WIDTH, 1, number of independent channels; legal >= 1.
- FILT_LEN, 4, consecutive stable synchronised samples required before the output changes; legal >= 1; 1 = filter bypass (output registered only).
- RST_VAL, 0 (WIDTH bits), per-channel reset level of the chain, filter output and edge history.

Ports:
- BitSync_CLK  input  1  destination clock; all logic on its rising edge.
- BitSync_RST  input  1  asynchronous, active-low reset.
- BitSync_ASYNC  input  WIDTH  asynchronous input levels.
- BitSync_SYNC  output  WIDTH  synchronised, filtered level per channel.
- BitSync_RISE  output  WIDTH  one-cycle pulse when BitSync_SYNC[i] goes 0->1.
- BitSync_FALL  output  WIDTH  one-cycle pulse when BitSync_SYNC[i] goes 1->0.

Behaviour:
- Reset is asynchronous, active-low on BitSync_RST, clocked by BitSync_CLK. While BitSync_RST = 0:
  - all chain flops and BitSync_SYNC[i] = RST_VAL[i];
  - filter counters = 0;
  - BitSync_RISE = BitSync_FALL = 0.
- Reset deassertion never produces an edge pulse.
- Chain: stage0 samples BitSync_ASYNC[i] each edge; stage k takes stage k-1. The tap d[i] = stage STAGES-1.
- Filter (per channel), counter width clog2(FILT_LEN) (minimum 1), evaluated each edge:
  - d == SYNC: counter <= 0, SYNC holds.
  - d != SYNC and counter < FILT_LEN-1: counter increments, SYNC holds.
  - d != SYNC and counter == FILT_LEN-1: SYNC <= d, counter <= 0.
- Latency: input stable from edge E1 (setup met) -> SYNC changes at edge E1+STAGES+FILT_LEN-1, i.e. STAGES+FILT_LEN edges inclusive.
- Glitch rejection: any excursion of d lasting fewer than FILT_LEN consecutive cycles produces no SYNC change; the counter restarts from 0 on each return to the SYNC level.
- Edge pulses: RISE/FALL are registered at the same edge SYNC updates, so they are coincident with the new SYNC value. Each is high for exactly one cycle and cleared on the next edge. RISE and FALL are never both high on one channel.
- Repeated toggling: minimum spacing between successive pulses on a channel is FILT_LEN cycles. With FILT_LEN = 1, d toggling every cycle gives SYNC toggling every cycle with alternating RISE/FALL.
- Reset mid-filter: the count is discarded; after release, filtering restarts from RST_VAL.
- Illegal parameters (STAGES < 2, FILT_LEN < 1, WIDTH < 1) cause an elaboration-time error.
- No combinational path from BitSync_ASYNC to any output; all outputs are flop-driven.
- Channels are independent: simultaneous changes on several channels may resolve on different cycles. Multi-bit data buses must not use this block; they require a handshake synchroniser.

Decomposition:
- Shared package/header bit_sync_pkg holds:
  - default STAGES constant (2);
  - clog2 function for counter width;
  - parameter-legality check macro.
- Sub-module bit_sync_filt_ch holds one channel (chain + filter counter + edge detect) with scalar ports, plus STAGES, FILT_LEN and a 1-bit RST_VAL.
- The top level instantiates it WIDTH times in a generate loop.

Test Plan:
- Reset: RST_VAL = 2'b10, WIDTH = 2, hold BitSync_RST = 0 -> SYNC = 2'b10, RISE = FALL = 0; release with ASYNC = 2'b10 -> no pulses for 20 cycles.
- Latency: STAGES = 2, FILT_LEN = 4, ASYNC[0] 0->1 before edge E1 -> SYNC[0] = 1 and RISE[0] = 1 after edge E1+5, RISE[0] = 0 after E1+6.
- Glitch: FILT_LEN = 4, ASYNC[0] high for 3 cycles then low -> SYNC[0] stays 0, no RISE; high for 4 cycles -> SYNC rises, then FALL exactly 4 cycles after d returns low.
- Bypass: FILT_LEN = 1, STAGES = 3, ASYNC toggling every cycle -> SYNC follows ASYNC delayed 3 edges, with alternating RISE/FALL each cycle.
- Reset mid-filter: FILT_LEN = 8, ASYNC high for 5 cycles, assert BitSync_RST for 1 cycle, keep ASYNC high -> after release SYNC rises exactly STAGES+8 edges later, one RISE.
- Channel independence: WIDTH = 4, walk a single 1 across ASYNC bits -> each SYNC bit/pulse occurs only on its own channel, others stay at 0.

Source files
------------

// File: rtl/bit_sync_pkg.sv
// Shared constants and helpers for the bit_sync_filt level synchroniser.
// Holds the default chain depth, counter-width function and parameter check.
package bit_sync_pkg;

   localparam int unsigned DEF_STAGES = 2;

   // Bits needed to count 0..val-1, never less than one.
   function automatic int unsigned clog2_min1(input int unsigned val);
      int unsigned res;
      res = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << res) < 64'(val)) res = res + 1;
      end
      return (res == 0) ? 1 : res;
   endfunction

endpackage

`define BIT_SYNC_PARAM_CHECK(ok) \
   if (!(ok)) begin : g_param_err \
      $error("bit_sync_filt: illegal parameters (need STAGES>=2, WIDTH>=1, FILT_LEN>=1)"); \
   end

// File: rtl/bit_sync_filt_ch.sv
// One synchroniser channel: metastability chain, stable-count glitch filter,
// and registered rise/fall pulses coincident with the filtered level change.
module bit_sync_filt_ch
   import bit_sync_pkg::*;
#(
   parameter int unsigned STAGES   = DEF_STAGES,
   parameter int unsigned FILT_LEN = 4,
   parameter logic        RST_VAL  = 1'b0
) (
   input  logic BitSync_CLK,
   input  logic BitSync_RST,
   input  logic i_async,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall
);

   localparam int unsigned     CNT_W   = clog2_min1(FILT_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);

   logic [STAGES-1:0] r_chain;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_sync;
   logic              r_rise;
   logic              r_fall;

   logic              w_tap;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_sync_nxt;
   logic              w_rise_nxt;
   logic              w_fall_nxt;

   assign w_tap = r_chain[STAGES-1];

   // Count consecutive samples that disagree with the output; any agreeing
   // sample restarts the qualification.
   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_sync_nxt = r_sync;
      w_rise_nxt = 1'b0;
      w_fall_nxt = 1'b0;
      if (w_tap == r_sync) begin
         w_cnt_nxt = '0;
      end else if (r_cnt == CNT_MAX) begin
         w_cnt_nxt  = '0;
         w_sync_nxt = w_tap;
         w_rise_nxt = w_tap;
         w_fall_nxt = ~w_tap;
      end else begin
         w_cnt_nxt = r_cnt + 1'b1;
      end
   end

   always_ff @(posedge BitSync_CLK or negedge BitSync_RST) begin
      if (!BitSync_RST) begin
         r_chain <= {STAGES{RST_VAL}};
         r_cnt   <= '0;
         r_sync  <= RST_VAL;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_chain <= {r_chain[STAGES-2:0], i_async};
         r_cnt   <= w_cnt_nxt;
         r_sync  <= w_sync_nxt;
         r_rise  <= w_rise_nxt;
         r_fall  <= w_fall_nxt;
      end
   end

   assign o_sync = r_sync;
   assign o_rise = r_rise;
   assign o_fall = r_fall;

endmodule

// File: rtl/bit_sync_filt.sv
// Multi-channel level synchroniser with per-channel glitch filter and edge pulses.
// Channels are independent; not suitable for coherent multi-bit buses.
module bit_sync_filt
   import bit_sync_pkg::*;
#(
   parameter int unsigned    STAGES   = DEF_STAGES,
   parameter int unsigned    WIDTH    = 1,
   parameter int unsigned    FILT_LEN = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             BitSync_CLK,
   input  logic             BitSync_RST,
   input  logic [WIDTH-1:0] BitSync_ASYNC,
   output logic [WIDTH-1:0] BitSync_SYNC,
   output logic [WIDTH-1:0] BitSync_RISE,
   output logic [WIDTH-1:0] BitSync_FALL
);

   `BIT_SYNC_PARAM_CHECK((STAGES >= 2) && (WIDTH >= 1) && (FILT_LEN >= 1))

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
      bit_sync_filt_ch #(
         .STAGES  (STAGES),
         .FILT_LEN(FILT_LEN),
         .RST_VAL (RST_VAL[gi])
      ) u_ch (
         .BitSync_CLK(BitSync_CLK),
         .BitSync_RST(BitSync_RST),
         .i_async    (BitSync_ASYNC[gi]),
         .o_sync     (BitSync_SYNC[gi]),
         .o_rise     (BitSync_RISE[gi]),
         .o_fall     (BitSync_FALL[gi])
      );
   end

endmodule

// File: tb/tb_bit_sync_filt.sv
// Bench for bit_sync_filt: three configurations checked every cycle against a
// window-based reference model, plus directed latency/glitch/reset checks.
module tb_bit_sync_filt;

   localparam int         ST[3] = '{2, 3, 2};
   localparam int         FL[3] = '{4, 1, 8};
   localparam int         W[3]  = '{2, 1, 4};
   localparam logic [3:0] RV[3] = '{4'b0010, 4'b0000, 4'b0000};
   localparam int         HLEN  = 1024;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] a0;
   logic       a1;
   logic [3:0] a2;
   logic [1:0] s0, r0, f0;
   logic       s1, r1, f1;
   logic [3:0] s2, r2, f2;

   int errors = 0;
   int checks = 0;

   logic [3:0] hist [3][HLEN];
   logic [3:0] m_sync [3];
   logic [3:0] m_rise [3];
   logic [3:0] m_fall [3];
   int         last_chg [3][4];
   int         n;

   always #5 clk = ~clk;

   bit_sync_filt #(.STAGES(2), .WIDTH(2), .FILT_LEN(4), .RST_VAL(2'b10)) u0 (
      .BitSync_CLK(clk), .BitSync_RST(rst_n), .BitSync_ASYNC(a0),
      .BitSync_SYNC(s0), .BitSync_RISE(r0), .BitSync_FALL(f0)
   );
   bit_sync_filt #(.STAGES(3), .WIDTH(1), .FILT_LEN(1), .RST_VAL(1'b0)) u1 (
      .BitSync_CLK(clk), .BitSync_RST(rst_n), .BitSync_ASYNC(a1),
      .BitSync_SYNC(s1), .BitSync_RISE(r1), .BitSync_FALL(f1)
   );
   bit_sync_filt #(.STAGES(2), .WIDTH(4), .FILT_LEN(8), .RST_VAL(4'b0000)) u2 (
      .BitSync_CLK(clk), .BitSync_RST(rst_n), .BitSync_ASYNC(a2),
      .BitSync_SYNC(s2), .BitSync_RISE(r2), .BitSync_FALL(f2)
   );

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %b want %b", tag, obs, exp);
      end
   endtask

   // Tap value seen by the filter at edge j: input sampled STAGES edges earlier.
   function automatic logic d_at(input int k, input int ch, input int j);
      logic [3:0] rv;
      rv = RV[k];
      if (j - ST[k] < 0) return rv[ch];
      return hist[k][j - ST[k]][ch];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_sync[k] = RV[k];
         m_rise[k] = '0;
         m_fall[k] = '0;
         for (int ch = 0; ch < 4; ch++) last_chg[k][ch] = -1;
      end
      n = 0;
   endtask

   // Output flips at edge n iff the last FILT_LEN taps, all after the previous
   // flip, disagree with the current output.
   task automatic model_edge();
      for (int k = 0; k < 3; k++) begin
         m_rise[k] = '0;
         m_fall[k] = '0;
         for (int ch = 0; ch < W[k]; ch++) begin
            int start;
            bit chg;
            start = n - FL[k] + 1;
            chg   = (start > last_chg[k][ch]);
            for (int j = start; j <= n; j++)
               if (j >= 0 && d_at(k, ch, j) == m_sync[k][ch]) chg = 1'b0;
            if (chg) begin
               m_sync[k][ch] = ~m_sync[k][ch];
               m_rise[k][ch] = m_sync[k][ch];
               m_fall[k][ch] = ~m_sync[k][ch];
               last_chg[k][ch] = n;
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, " u0.sync"}, {2'b00, s0}, m_sync[0]);
      chk({tag, " u0.rise"}, {2'b00, r0}, m_rise[0]);
      chk({tag, " u0.fall"}, {2'b00, f0}, m_fall[0]);
      chk({tag, " u1.sync"}, {3'b000, s1}, m_sync[1]);
      chk({tag, " u1.rise"}, {3'b000, r1}, m_rise[1]);
      chk({tag, " u1.fall"}, {3'b000, f1}, m_fall[1]);
      chk({tag, " u2.sync"}, s2, m_sync[2]);
      chk({tag, " u2.rise"}, r2, m_rise[2]);
      chk({tag, " u2.fall"}, f2, m_fall[2]);
   endtask

   task automatic step(input string tag);
      if (n < HLEN) begin
         hist[0][n] = {2'b00, a0};
         hist[1][n] = {3'b000, a1};
         hist[2][n] = a2;
      end
      @(posedge clk);
      #1;
      if (n < HLEN) begin
         model_edge();
         check_all(tag);
      end
      n++;
   endtask

   initial begin
      int cnt;
      rst_n = 1'b0;
      a0 = 2'b10;
      a1 = 1'b0;
      a2 = 4'b0000;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all("reset");
      rst_n = 1'b1;

      repeat (20) step("idle");

      // Latency: ch0 rises at the sixth edge counted from the first sampling edge.
      a0 = 2'b11;
      repeat (6) step("lat");
      chk("lat sync0", {3'b000, s0[0]}, 4'd1);
      chk("lat rise0", {3'b000, r0[0]}, 4'd1);
      step("lat");
      chk("lat rise0 clr", {3'b000, r0[0]}, 4'd0);
      a0 = 2'b10;
      repeat (12) step("lat_fall");

      // Glitch of 3 cycles rejected.
      cnt = 0;
      a0 = 2'b11;
      for (int i = 0; i < 3; i++) begin step("glitch3"); cnt += int'(r0[0]); end
      a0 = 2'b10;
      for (int i = 0; i < 12; i++) begin step("glitch3"); cnt += int'(r0[0]); end
      chk("glitch3 rises", 4'(cnt), 4'd0);

      // Pulse of 4 cycles passes; fall four taps after d returns low.
      a0 = 2'b11;
      repeat (4) step("pulse4");
      a0 = 2'b10;
      for (int i = 1; i <= 12; i++) begin
         step("pulse4");
         if (i == 2) chk("pulse4 rise", {3'b000, r0[0]}, 4'd1);
         if (i == 5) chk("pulse4 high", {3'b000, s0[0]}, 4'd1);
         if (i == 6) chk("pulse4 fall", {3'b000, f0[0]}, 4'd1);
      end

      // Bypass channel toggling every cycle.
      for (int i = 1; i <= 20; i++) begin
         a1 = ~a1;
         step("bypass");
         if (i >= 4) chk("bypass alt", {3'b000, r1 ^ f1}, 4'd1);
      end
      a1 = 1'b0;

      // Walking one across the four independent channels.
      for (int b = 0; b < 4; b++) begin
         a2 = 4'b0001 << b;
         repeat (11) step("walk");
         chk("walk sync", s2, 4'b0001 << b);
         a2 = 4'b0000;
         repeat (12) step("walk");
      end

      // Random activity, each bit flipping with probability 1/4 per cycle.
      for (int i = 0; i < 150; i++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 3) == 0) a2[b] = ~a2[b];
            if (b < 2 && $urandom_range(0, 3) == 0) a0[b] = ~a0[b];
         end
         if ($urandom_range(0, 3) == 0) a1 = ~a1;
         step("rand");
      end

      // Reset in the middle of qualification.
      a0 = 2'b10;
      a1 = 1'b0;
      a2 = 4'b0000;
      repeat (12) step("pre_rst");
      a2 = 4'b0001;
      repeat (5) step("pre_rst");
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("mid_rst");
      @(posedge clk);
      #1;
      check_all("mid_rst");
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 1; i <= 20; i++) begin
         step("post_rst");
         cnt += int'(r2[0]);
         if (i == 9) chk("post_rst early", {3'b000, s2[0]}, 4'd0);
         if (i == 10) chk("post_rst rise", {3'b000, s2[0] & r2[0]}, 4'd1);
      end
      chk("post_rst rises", 4'(cnt), 4'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
